// File: rtl/freq_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module   : freq_divider_prog
//  Brief    : Synchronous programmable clock divider. Produces a square-wave
//             or pulse output, a one-cycle tick per period, and a free-running
//             power-of-two tap bus. A new divide ratio takes effect only at a
//             period boundary, so no output period is ever cut short.
//  Revision : 1.0 - initial release
// ============================================================================
module freq_divider_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 32768
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  input  logic             mode,
  output logic             clock_out,
  output logic             tick,
  output logic             pending,
  output logic             load_err,
  output logic [WIDTH-1:0] taps
);

  localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] c_zero        = '0;
  localparam logic [WIDTH-1:0] c_one         = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_two         = WIDTH'(2);

  // State registers and their next-state values
  logic [WIDTH-1:0] cnt_q,       cnt_d;
  logic [WIDTH-1:0] div_q,       div_d;
  logic [WIDTH-1:0] pend_q,      pend_d;
  logic             pending_q,   pending_d;
  logic             mode_q,      mode_d;
  logic             clock_out_q, clock_out_d;
  logic             tick_q,      tick_d;
  logic             load_err_q,  load_err_d;
  logic [WIDTH-1:0] taps_q,      taps_d;

  // Decoded conditions for the current cycle
  logic             w_terminal;
  logic             w_load_ok;
  logic             w_load_bad;

  // Period boundary and load qualification.
  // A ratio below 2 cannot produce a meaningful period, so such loads are refused.
  always_comb begin
    w_terminal = enable && (cnt_q == (div_q - c_one));
    w_load_ok  = div_load && (div_in >= c_two);
    w_load_bad = div_load && (div_in <  c_two);
  end

  // Next-state logic for the counter, ratio staging, mode and outputs.
  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    pend_d      = pend_q;
    pending_d   = pending_q;
    mode_d      = mode_q;
    taps_d      = taps_q;
    tick_d      = 1'b0;
    load_err_d  = 1'b0;
    clock_out_d = clock_out_q;

    // Period counter and free-running tap counter only move when enabled.
    if (enable) begin
      cnt_d  = w_terminal ? c_zero : (cnt_q + c_one);
      taps_d = taps_q + c_one;
    end

    // Ratio staging: a load on the boundary cycle is used immediately for the
    // next period; otherwise it waits in pend_q until the next boundary.
    // Later loads overwrite an earlier waiting ratio.
    if (w_load_ok && w_terminal) begin
      div_d     = div_in;
      pend_d    = div_in;
      pending_d = 1'b0;
    end else if (w_load_ok) begin
      pend_d    = div_in;
      pending_d = 1'b1;
    end else if (w_terminal && pending_q) begin
      div_d     = pend_q;
      pending_d = 1'b0;
    end

    // Mode switches only at a boundary so a period is never truncated.
    if (w_terminal) begin
      mode_d = mode;
    end

    tick_d     = w_terminal;
    load_err_d = w_load_bad;

    // The output register is loaded with the value that matches the counter
    // and ratio it will be presented alongside, keeping them cycle-aligned.
    if (mode_d) begin
      clock_out_d = w_terminal;
    end else begin
      clock_out_d = (cnt_d >= (div_d >> 1));
    end
  end

  // State register with synchronous reset dominating all inputs.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      cnt_q       <= c_zero;
      div_q       <= c_default_div;
      pend_q      <= c_zero;
      pending_q   <= 1'b0;
      mode_q      <= 1'b0;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
      load_err_q  <= 1'b0;
      taps_q      <= c_zero;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      clock_out_q <= clock_out_d;
      tick_q      <= tick_d;
      load_err_q  <= load_err_d;
      taps_q      <= taps_d;
    end
  end

  assign clock_out = clock_out_q;
  assign tick      = tick_q;
  assign pending   = pending_q;
  assign load_err  = load_err_q;
  assign taps      = taps_q;

endmodule
`default_nettype wire

// File: tb/tb_freq_divider_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_freq_divider_prog
//  Brief    : Directed self-checking bench for freq_divider_prog with a small
//             default ratio of 6.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_freq_divider_prog;

  localparam int WIDTH       = 16;
  localparam int DEFAULT_DIV = 6;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             mode;
  logic             clock_out;
  logic             tick;
  logic             pending;
  logic             load_err;
  logic [WIDTH-1:0] taps;

  int               checks   = 0;
  int               failures = 0;
  logic [WIDTH-1:0] exp_taps = '0;

  freq_divider_prog #(
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clock_in  (clk),
    .reset     (reset),
    .enable    (enable),
    .div_in    (div_in),
    .div_load  (div_load),
    .mode      (mode),
    .clock_out (clock_out),
    .tick      (tick),
    .pending   (pending),
    .load_err  (load_err),
    .taps      (taps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; the expected tap count follows the inputs seen at the edge.
  task automatic cyc();
    @(posedge clk);
    if (reset) exp_taps = '0;
    else if (enable) exp_taps = exp_taps + 1'b1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 1'b0; div_load = 1'b0; div_in = '0;
    cyc(); cyc();
    chk("rst_clock_out", clock_out, 0);
    chk("rst_tick",      tick,      0);
    chk("rst_pending",   pending,   0);
    chk("rst_load_err",  load_err,  0);
    chk("rst_taps",      taps,      0);

    // Default ratio 6: 000111 repeated, tick at cycles 6 and 12 (and 18)
    reset = 1'b0;
    for (int s = 1; s <= 18; s++) begin
      cyc();
      chk("def_clock_out", clock_out, 32'((s % 6) >= 3));
      chk("def_tick",      tick,      32'((s % 6) == 0));
    end
    chk("def_taps18", taps, 18);

    // Reload 4 requested at cnt=2, applied at the cnt=5 boundary
    cyc(); cyc();
    chk("rl_pre_clock_out", clock_out, 0);
    div_in = 16'd4; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    chk("rl_pending_c3",   pending,   1);
    chk("rl_clock_out_c3", clock_out, 1);
    cyc();
    chk("rl_pending_c4", pending, 1);
    cyc();
    chk("rl_pending_c5", pending, 1);
    cyc();
    chk("rl_pending_apply", pending,   0);
    chk("rl_tick_apply",    tick,      1);
    chk("rl_co_apply",      clock_out, 0);
    for (int j = 1; j <= 8; j++) begin
      cyc();
      chk("rl4_clock_out", clock_out, 32'((j % 4) >= 2));
      chk("rl4_tick",      tick,      32'((j % 4) == 0));
    end

    // Rejected loads, then overwrite of a waiting ratio, with counting paused
    enable = 1'b0; div_load = 1'b1; div_in = 16'd1;
    cyc();
    chk("rej1_load_err", load_err,  1);
    chk("rej1_pending",  pending,   0);
    chk("rej1_tick",     tick,      0);
    chk("rej1_co",       clock_out, 0);
    div_in = 16'd0;
    cyc();
    chk("rej0_load_err", load_err, 1);
    chk("rej0_pending",  pending,  0);
    div_in = 16'd9;
    cyc();
    chk("ld9_load_err", load_err, 0);
    chk("ld9_pending",  pending,  1);
    div_in = 16'd3;
    cyc();
    chk("ld3_load_err", load_err, 0);
    chk("ld3_pending",  pending,  1);
    chk("ld3_taps",     taps,     exp_taps);
    div_load = 1'b0; enable = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      cyc();
      chk("ow_rem_clock_out", clock_out, 32'(j >= 2));
      chk("ow_rem_pending",   pending,   1);
    end
    for (int m = 0; m <= 5; m++) begin
      cyc();
      chk("div3_clock_out", clock_out, 32'((m % 3) >= 1));
      chk("div3_tick",      tick,      32'((m % 3) == 0));
      chk("div3_pending",   pending,   0);
    end

    // Load 7 exactly on the boundary cycle (cnt=2 of ratio 3)
    div_in = 16'd7; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    chk("sim_tick",      tick,      1);
    chk("sim_pending",   pending,   0);
    chk("sim_clock_out", clock_out, 0);
    for (int s = 1; s <= 7; s++) begin
      cyc();
      chk("div7_clock_out", clock_out, 32'((s % 7) >= 3));
      chk("div7_tick",      tick,      32'(s == 7));
      chk("div7_pending",   pending,   0);
    end

    // Switch to pulse mode mid-period: square period completes first
    cyc(); cyc();
    mode = 1'b1;
    for (int s = 3; s <= 6; s++) begin
      cyc();
      chk("msw_square_co", clock_out, 1);
      chk("msw_tick",      tick,      0);
    end
    for (int s = 7; s <= 14; s++) begin
      cyc();
      chk("pulse_tick",      tick,      32'((s % 7) == 0));
      chk("pulse_clock_out", clock_out, 32'((s % 7) == 0));
    end

    // Pause counting for 5 cycles at cnt=2, then resume
    cyc(); cyc();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("hold_tick",      tick,      0);
      chk("hold_clock_out", clock_out, 0);
      chk("hold_taps",      taps,      exp_taps);
    end
    enable = 1'b1;
    for (int s = 3; s <= 6; s++) begin
      cyc();
      chk("resume_tick", tick, 0);
    end
    cyc();
    chk("resume_wrap_tick", tick,      1);
    chk("resume_wrap_co",   clock_out, 1);
    chk("resume_taps",      taps,      exp_taps);

    // Reset while a ratio is waiting and cnt=3
    mode = 1'b0;
    cyc();
    div_in = 16'd5; div_load = 1'b1;
    cyc();
    div_load = 1'b0;
    cyc();
    chk("mid_pending_before", pending, 1);
    reset = 1'b1;
    cyc();
    chk("mid_rst_clock_out", clock_out, 0);
    chk("mid_rst_tick",      tick,      0);
    chk("mid_rst_pending",   pending,   0);
    chk("mid_rst_load_err",  load_err,  0);
    chk("mid_rst_taps",      taps,      0);
    reset = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      cyc();
      chk("post_rst_clock_out", clock_out, 32'((s % 6) >= 3));
      chk("post_rst_tick",      tick,      32'(s == 6));
      chk("post_rst_pending",   pending,   0);
    end
    chk("post_rst_taps", taps, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
